cpu_sequencer: RTL and testbench

Control unit for the 8-bit Simple RISC CPU. It is an 8-phase instruction sequencer that drives the control points of the datapath: the program counter, instruction register, accumulator, address mux, the 32x8 bidirectional memory (en/rw) and the accumulator tri-state bus buffer. It consumes the 3-bit opcode from the instruction register and the zero flag from the ALU. It also provides halt/resume, stall and a retired-instruction counter for debug.

---
 rtl/cpu_sequencer.sv | 155 +++++++++++++++
 tb/tb_cpu_sequencer.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: 8-phase instruction sequencer for the 8-bit Simple RISC CPU.
// Drives PC/IR/ACC load strobes, address mux, memory enable/direction and
// the accumulator bus buffer. Adds halt/resume, stall and a retired count.
//
//  state      | meaning
//  -----------+-----------------------------------------------------------
//  INST_ADDR  | PC on address bus
//  INST_FETCH | memory read of instruction
//  INST_LOAD  | instruction register load
//  DECODE     | opcode valid; HLT parks here with halted=1
//  INC        | PC increment
//  OP_ADDR    | operand address on bus, read for ALU ops
//  ALU_OP     | operand read, SKZ skip, JMP load, STO bus drive
//  STORE      | accumulator load or memory write, JMP load
module cpu_sequencer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             resume,
    input  logic [2:0]       opcode,
    input  logic             zero,
    output logic             sel,
    output logic             mem_en,
    output logic             mem_rw,
    output logic             ld_ir,
    output logic             ld_ac,
    output logic             ld_pc,
    output logic             inc_pc,
    output logic             data_e,
    output logic             halt,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [2:0] {
        INST_ADDR  = 3'd0,
        INST_FETCH = 3'd1,
        INST_LOAD  = 3'd2,
        DECODE     = 3'd3,
        INC        = 3'd4,
        OP_ADDR    = 3'd5,
        ALU_OP     = 3'd6,
        STORE      = 3'd7
    } phase_t;

    localparam logic [2:0] OP_HLT = 3'b000;
    localparam logic [2:0] OP_SKZ = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_LDA = 3'b101;
    localparam logic [2:0] OP_STO = 3'b110;
    localparam logic [2:0] OP_JMP = 3'b111;

    phase_t           state;
    logic             halted;
    logic [CNT_W-1:0] count;
    logic             alu_op;
    logic             is_sto;
    logic             is_jmp;
    logic             is_skz;

    assign alu_op = (opcode == OP_ADD) || (opcode == OP_AND) ||
                    (opcode == OP_XOR) || (opcode == OP_LDA);
    assign is_sto = (opcode == OP_STO);
    assign is_jmp = (opcode == OP_JMP);
    assign is_skz = (opcode == OP_SKZ);

    // Phase, halt flag and retired count; everything frozen while enable=0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= INST_ADDR;
            halted <= 1'b0;
            count  <= '0;
        end else if (enable) begin
            if (halted) begin
                // Resume skips straight to INC so the PC steps past the HLT.
                if (resume) begin
                    halted <= 1'b0;
                    state  <= INC;
                end
            end else begin
                case (state)
                    DECODE: begin
                        if (opcode == OP_HLT) begin
                            halted <= 1'b1;
                        end else begin
                            state <= INC;
                        end
                    end
                    STORE: begin
                        state <= INST_ADDR;
                        count <= count + 1'b1;
                    end
                    default: state <= phase_t'(state + 3'd1);
                endcase
            end
        end
    end

    // Control point decode from the held phase plus current opcode/zero.
    always_comb begin
        sel    = 1'b1;
        mem_en = 1'b0;
        mem_rw = 1'b0;
        ld_ir  = 1'b0;
        ld_ac  = 1'b0;
        ld_pc  = 1'b0;
        inc_pc = 1'b0;
        data_e = 1'b0;
        if (!halted) begin
            case (state)
                INST_ADDR: sel = 1'b1;
                INST_FETCH: mem_en = 1'b1;
                INST_LOAD: begin
                    mem_en = 1'b1;
                    ld_ir  = 1'b1;
                end
                DECODE: sel = 1'b1;
                INC: begin
                    sel    = 1'b0;
                    inc_pc = 1'b1;
                end
                OP_ADDR: begin
                    sel    = 1'b0;
                    mem_en = alu_op;
                end
                ALU_OP: begin
                    sel    = 1'b0;
                    mem_en = alu_op;
                    inc_pc = is_skz & zero;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                STORE: begin
                    sel    = 1'b0;
                    mem_en = alu_op | is_sto;
                    mem_rw = is_sto;
                    ld_ac  = alu_op;
                    ld_pc  = is_jmp;
                    data_e = is_sto;
                end
                default: sel = 1'b1;
            endcase
        end
    end

    // Halting parks the phase register at DECODE, so phase reads 3 there.
    assign phase       = state;
    assign halt        = halted;
    assign instr_count = count;

endmodule

// File: tb/tb_cpu_sequencer.sv
// Bench for cpu_sequencer: directed vectors, expected responses queued by
// the stimulus and checked by an independent monitor process.
module tb_cpu_sequencer;

    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          enable;
    logic          resume;
    logic [2:0]    opcode;
    logic          zero;
    logic          sel, mem_en, mem_rw, ld_ir, ld_ac, ld_pc, inc_pc, data_e;
    logic          halt;
    logic [2:0]    phase;
    logic [CW-1:0] instr_count;
    logic          kick = 1'b0;

    cpu_sequencer #(.CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .resume      (resume),
        .opcode      (opcode),
        .zero        (zero),
        .sel         (sel),
        .mem_en      (mem_en),
        .mem_rw      (mem_rw),
        .ld_ir       (ld_ir),
        .ld_ac       (ld_ac),
        .ld_pc       (ld_pc),
        .inc_pc      (inc_pc),
        .data_e      (data_e),
        .halt        (halt),
        .phase       (phase),
        .instr_count (instr_count)
    );

    always #5 clk = ~clk;

    localparam logic [2:0] HLT = 3'b000, SKZ = 3'b001, ADD = 3'b010,
                           LDA = 3'b101, STO = 3'b110, JMP = 3'b111;

    // ctrl bit order: {sel, mem_en, mem_rw, ld_ir, ld_ac, ld_pc, inc_pc, data_e}
    // Tables indexed by phase 0..7, hand-derived per opcode.
    logic [7:0] lda_tab  [8] = '{8'h80, 8'hC0, 8'hD0, 8'h80, 8'h02, 8'h40, 8'h40, 8'h48};
    logic [7:0] sto_tab  [8] = '{8'h80, 8'hC0, 8'hD0, 8'h80, 8'h02, 8'h00, 8'h01, 8'h61};
    logic [7:0] skz1_tab [8] = '{8'h80, 8'hC0, 8'hD0, 8'h80, 8'h02, 8'h00, 8'h02, 8'h00};
    logic [7:0] skz0_tab [8] = '{8'h80, 8'hC0, 8'hD0, 8'h80, 8'h02, 8'h00, 8'h00, 8'h00};
    logic [7:0] jmp_tab  [8] = '{8'h80, 8'hC0, 8'hD0, 8'h80, 8'h02, 8'h00, 8'h04, 8'h04};
    logic [7:0] hlt_tab  [8] = '{8'h80, 8'hC0, 8'hD0, 8'h80, 8'h02, 8'h00, 8'h00, 8'h00};

    typedef struct {
        logic [2:0]    ph;
        logic          h;
        logic [7:0]    c;
        logic [CW-1:0] n;
        string         nm;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    logic [7:0] ctrl_now;
    assign ctrl_now = {sel, mem_en, mem_rw, ld_ir, ld_ac, ld_pc, inc_pc, data_e};

    // Monitor: compares after every clock edge or an async-check kick.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk or posedge kick);
            #2;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                checks++;
                if ({phase, halt, ctrl_now, instr_count} !== {e.ph, e.h, e.c, e.n}) begin
                    errors++;
                    $display("FAIL %s: got phase=%0d halt=%b ctrl=%b cnt=%0d, want phase=%0d halt=%b ctrl=%b cnt=%0d",
                             e.nm, phase, halt, ctrl_now, instr_count, e.ph, e.h, e.c, e.n);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic push(input logic [2:0] ph, input logic h, input logic [7:0] c,
                        input logic [CW-1:0] n, input string nm);
        exp_t e;
        e.ph = ph; e.h = h; e.c = c; e.n = n; e.nm = nm;
        sb.push_back(e);
    endtask

    // Drive inputs for the coming edge, queue the expected result, wait a cycle.
    task automatic step(input logic en, input logic rs, input logic [2:0] op, input logic z,
                        input logic [2:0] ph, input logic h, input logic [7:0] c,
                        input logic [CW-1:0] n, input string nm);
        enable = en; resume = rs; opcode = op; zero = z;
        push(ph, h, c, n, nm);
        @(negedge clk);
    endtask

    // Expected state checked immediately, with no clock edge.
    task automatic check_now(input logic [2:0] ph, input logic h, input logic [7:0] c,
                             input logic [CW-1:0] n, input string nm);
        push(ph, h, c, n, nm);
        kick = 1'b1;
        #1 kick = 1'b0;
    endtask

    // One full instruction from phase 0 back to phase 0. Opcode is randomised
    // in phases where it must not matter.
    task automatic instr(input logic [2:0] op, input logic z, input logic rs,
                         input logic [7:0] tab [8], input logic [CW-1:0] cnt_before,
                         input string nm);
        for (int p = 1; p <= 8; p++) begin
            int         ph;
            logic [2:0] drv;
            ph  = p % 8;
            drv = (ph <= 3) ? 3'($urandom_range(0, 7)) : op;
            step(1'b1, rs, drv, z, 3'(ph), 1'b0, tab[ph],
                 (ph == 0) ? cnt_before + 1'b1 : cnt_before, nm);
        end
    endtask

    logic [CW-1:0] ec;

    initial begin
        rst = 1'b1; enable = 1'b1; resume = 1'b0; opcode = LDA; zero = 1'b0;
        ec = '0;
        #1;
        check_now(3'd0, 1'b0, 8'h80, '0, "reset_initial");
        @(negedge clk);
        rst = 1'b0;

        instr(LDA, 1'b0, 1'b0, lda_tab, ec, "lda");            ec++;
        instr(STO, 1'b0, 1'b0, sto_tab, ec, "sto");            ec++;
        instr(SKZ, 1'b1, 1'b0, skz1_tab, ec, "skz_zero1");     ec++;
        instr(SKZ, 1'b0, 1'b1, skz0_tab, ec, "skz_zero0_res"); ec++;
        instr(JMP, 1'b0, 1'b0, jmp_tab, ec, "jmp");            ec++;
        instr(ADD, 1'b1, 1'b0, lda_tab, ec, "add");            ec++;

        // Stall for 5 cycles in phase 6.
        for (int p = 1; p <= 6; p++)
            step(1'b1, 1'b0, LDA, 1'b0, 3'(p), 1'b0, lda_tab[p], ec, "stall_pre");
        for (int i = 0; i < 5; i++)
            step(1'b0, 1'b0, LDA, 1'b0, 3'd6, 1'b0, 8'h40, ec, "stall_hold");
        step(1'b1, 1'b0, LDA, 1'b0, 3'd7, 1'b0, 8'h48, ec, "stall_p7");
        step(1'b1, 1'b0, LDA, 1'b0, 3'd0, 1'b0, 8'h80, ec + 1'b1, "stall_done");
        ec++;

        // Halt, hold, ignored stalled resume, then resume into INC.
        for (int p = 1; p <= 3; p++)
            step(1'b1, 1'b0, HLT, 1'b0, 3'(p), 1'b0, hlt_tab[p], ec, "hlt_fetch");
        for (int i = 0; i < 20; i++)
            step(1'b1, 1'b0, HLT, 1'b0, 3'd3, 1'b1, 8'h80, ec, "halted");
        step(1'b0, 1'b1, HLT, 1'b0, 3'd3, 1'b1, 8'h80, ec, "resume_stalled");
        step(1'b1, 1'b1, HLT, 1'b0, 3'd4, 1'b0, 8'h02, ec, "resume");
        for (int p = 5; p <= 7; p++)
            step(1'b1, 1'b0, HLT, 1'b0, 3'(p), 1'b0, hlt_tab[p], ec, "hlt_tail");
        step(1'b1, 1'b0, HLT, 1'b0, 3'd0, 1'b0, 8'h80, ec + 1'b1, "hlt_done");
        ec++;

        // Asynchronous reset in phase 5 of an LDA.
        for (int p = 1; p <= 5; p++)
            step(1'b1, 1'b0, LDA, 1'b0, 3'(p), 1'b0, lda_tab[p], ec, "pre_reset");
        #2 rst = 1'b1;
        check_now(3'd0, 1'b0, 8'h80, '0, "reset_async");
        @(negedge clk);
        check_now(3'd0, 1'b0, 8'h80, '0, "reset_held");
        rst = 1'b0;
        ec = '0;
        for (int p = 1; p <= 3; p++)
            step(1'b1, 1'b0, LDA, 1'b0, 3'(p), 1'b0, lda_tab[p], ec, "post_reset");
        for (int p = 4; p <= 7; p++)
            step(1'b1, 1'b0, LDA, 1'b0, 3'(p), 1'b0, lda_tab[p], ec, "post_reset_tail");
        step(1'b1, 1'b0, LDA, 1'b0, 3'd0, 1'b0, 8'h80, ec + 1'b1, "post_reset_done");
        ec++;

        // Count wrap: 15 more instructions bring the 4-bit count back to 0.
        for (int i = 0; i < 15; i++) begin
            instr(LDA, 1'b0, 1'b0, lda_tab, ec, "wrap");
            ec++;
        end
        push(3'd0, 1'b0, 8'h80, 4'd0, "wrap_zero");
        kick = 1'b1;
        #1 kick = 1'b0;

        repeat (3) @(negedge clk);
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending, want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
